// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Issue stage in front of the ALU. Each request is taken with a valid/ready
// handshake and then driven onto the ALU input port group. An unsplit request
// sends both operands together. A split request sends A first, holds it for
// req_gap idle cycles, and then sends B. After issue, the block waits out the
// command-dependent ALU latency. It then captures the result and flags into a
// response register, which is held until the consumer accepts it.
//
// Ports
//   clk, reset                 clock (rising edge), async active-low reset
//   req_valid / req_ready      request handshake
//   req_mode, req_cmd, req_cin operation fields
//   req_opa, req_opb           operands (N bits)
//   req_inp_valid              inp_valid used for unsplit issue
//   req_split, req_gap         split delivery, idle cycles between A and B
//   alu_*  (out)               ALU input port group
//   alu_res, alu_err..alu_e    ALU result and flags
//   rsp_valid / rsp_ready      response handshake
//   rsp_res, rsp_flags         captured result, {err,oflow,cout,g,l,e}
module alu_op_sequencer #(
  parameter int N       = 8,
  parameter int M       = 4,
  parameter int RES_LAT = 1,
  parameter int MUL_LAT = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic           req_mode,
  input  logic [M-1:0]   req_cmd,
  input  logic           req_cin,
  input  logic [N-1:0]   req_opa,
  input  logic [N-1:0]   req_opb,
  input  logic [1:0]     req_inp_valid,
  input  logic           req_split,
  input  logic [4:0]     req_gap,
  output logic           alu_ce,
  output logic           alu_mode,
  output logic [M-1:0]   alu_cmd,
  output logic [N-1:0]   alu_opa,
  output logic [N-1:0]   alu_opb,
  output logic           alu_cin,
  output logic [1:0]     alu_inp_valid,
  input  logic [N+1:0]   alu_res,
  input  logic           alu_err,
  input  logic           alu_oflow,
  input  logic           alu_cout,
  input  logic           alu_g,
  input  logic           alu_l,
  input  logic           alu_e,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [N+1:0]   rsp_res,
  output logic [5:0]     rsp_flags
);

  typedef enum logic [2:0] {IDLE, ISSUE, ISSUE_A, GAP, ISSUE_B, WAIT, RESP} state_t;

  typedef struct packed {
    logic         mode;
    logic [M-1:0] cmd;
    logic         cin;
    logic [N-1:0] opa;
    logic [N-1:0] opb;
    logic [1:0]   inp_valid;
    logic         split;
    logic [4:0]   gap;
  } req_t;

  localparam int LAT_MAX = (MUL_LAT > RES_LAT) ? MUL_LAT : RES_LAT;
  // The counter holds LAT-1 down to 0.
  localparam int LW = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
  localparam logic [LW-1:0] RES_LD = LW'(RES_LAT - 1);
  localparam logic [LW-1:0] MUL_LD = LW'(MUL_LAT - 1);

  state_t        state, state_nxt;
  req_t          req_in, req_q;
  logic          rdy_q;
  logic [4:0]    gap_cnt;
  logic [LW-1:0] lat_cnt;
  logic          accept, is_mul;
  logic          a_phase, b_phase, full_phase;

  assign req_in = '{req_mode, req_cmd, req_cin, req_opa, req_opb,
                    req_inp_valid, req_split, req_gap};

  // rdy_q mirrors (state == IDLE). It is registered so that it reads 0 while
  // reset is asserted.
  assign req_ready = rdy_q;
  assign accept    = req_valid & rdy_q;
  assign rsp_valid = (state == RESP);
  assign is_mul    = req_q.mode & ((req_q.cmd == M'(9)) | (req_q.cmd == M'(10)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rdy_q     <= 1'b0;
      req_q     <= '0;
      gap_cnt   <= '0;
      lat_cnt   <= '0;
      rsp_res   <= '0;
      rsp_flags <= '0;
    end else begin
      state <= state_nxt;
      rdy_q <= (state_nxt == IDLE);
      if (accept) begin
        req_q   <= req_in;
        gap_cnt <= req_gap;
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt - 5'd1;
      end
      // Keep the latency preset loaded until WAIT begins. req_q is already
      // stable by then, so the preset is correct on WAIT entry.
      if (state != WAIT)
        lat_cnt <= is_mul ? MUL_LD : RES_LD;
      else if (lat_cnt != '0)
        lat_cnt <= lat_cnt - LW'(1);
      if (state == WAIT && lat_cnt == '0) begin
        rsp_res   <= alu_res;
        rsp_flags <= {alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e};
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = req_split ? ISSUE_A : ISSUE;
      ISSUE:   state_nxt = WAIT;
      ISSUE_A: state_nxt = (req_q.gap != 5'd0) ? GAP : ISSUE_B;
      GAP:     if (gap_cnt == 5'd1) state_nxt = ISSUE_B;
      ISSUE_B: state_nxt = WAIT;
      WAIT:    if (lat_cnt == '0) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // In WAIT, the outputs of the last issue phase stay on the ALU inputs.
  always_comb begin
    a_phase    = (state == ISSUE_A) | (state == GAP);
    b_phase    = (state == ISSUE_B) | ((state == WAIT) & req_q.split);
    full_phase = (state == ISSUE)   | ((state == WAIT) & ~req_q.split);

    alu_ce        = 1'b0;
    alu_mode      = 1'b0;
    alu_cmd       = '0;
    alu_cin       = 1'b0;
    alu_opa       = '0;
    alu_opb       = '0;
    alu_inp_valid = 2'b00;
    if (a_phase | b_phase | full_phase) begin
      alu_ce   = 1'b1;
      alu_mode = req_q.mode;
      alu_cmd  = req_q.cmd;
      alu_cin  = req_q.cin;
      alu_opa  = req_q.opa;
    end
    if (full_phase) begin
      alu_opb       = req_q.opb;
      alu_inp_valid = req_q.inp_valid;
    end
    if (a_phase) alu_inp_valid = 2'b01;
    if (b_phase) begin
      alu_opb       = req_q.opb;
      alu_inp_valid = 2'b10;
    end
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Upstream issue stage for the ALU. Accepts one operation per valid/ready request, drives the ALU input port group (`ce`, `mode`, `cmd`, `opa`, `opb`, `cin`, `inp_valid`) with correct operand sequencing, waits the command-dependent ALU latency, then captures result and flags into a response register held until the consumer accepts it. Supports split-operand delivery (A first, B after a programmable gap) to exercise the ALU's 16-cycle operand timeout.

## Interface
- `N`, 8, operand width (ALU `n`); result width is N+2
- `M`, 4, command width (ALU `m`)
- `RES_LAT`, 1, ALU result latency in cycles for non-multiply commands (>=1)
- `MUL_LAT`, 2, ALU result latency for MUL_SHIFT/MUL_INC (>=1)

- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  sequencer can accept
- `req_mode`, `req_cmd`, `req_cin`  in  1/M/1  operation fields
- `req_opa`, `req_opb`  in  N each  operands
- `req_inp_valid`  in  2  inp_valid for unsplit issue
- `req_split`  in  1  1 = deliver A then B
- `req_gap`  in  5  idle cycles between A and B (0..31)
- `alu_ce`, `alu_mode`, `alu_cin`  out  1  to ALU
- `alu_cmd`  out  M;  `alu_opa`, `alu_opb`  out  N;  `alu_inp_valid`  out  2
- `alu_res`  in  N+2;  `alu_err`, `alu_oflow`, `alu_cout`, `alu_g`, `alu_l`, `alu_e`  in  1  from ALU
- `rsp_valid`  out  1  response held
- `rsp_ready`  in  1  consumer accepts
- `rsp_res`  out  N+2;  `rsp_flags`  out  6  {err,oflow,cout,g,l,e}

## Operation
- States: IDLE, ISSUE, ISSUE_A, GAP, ISSUE_B, WAIT, RESP.
- IDLE: `req_ready`=1, ALU outputs at idle values (`alu_ce`=0, `alu_inp_valid`=00, data 0). Handshake on req_valid&req_ready latches all req fields; go ISSUE_A if req_split else ISSUE.
- ISSUE: `alu_ce`=1, all fields driven from latch, `alu_inp_valid`=latched req_inp_valid; next WAIT.
- ISSUE_A: `alu_inp_valid`=01, opa driven, opb=0; next GAP if req_gap>0 else ISSUE_B.
- GAP: hold ISSUE_A outputs (`alu_ce`=1, inp_valid 01) for exactly req_gap cycles (5-bit down counter); next ISSUE_B.
- ISSUE_B: `alu_inp_valid`=10, opb driven, opa held; next WAIT.
- WAIT: hold last issued outputs; latency counter loaded with MUL_LAT when mode=1 and cmd in {9,10}, else RES_LAT. On the edge ending the final WAIT cycle capture `alu_res` and flags into rsp registers; next RESP.
- RESP: `rsp_valid`=1, rsp_* stable, ALU outputs back to idle values; on rsp_ready go IDLE.
- Commands are not checked; illegal cmd/inp_valid=00 pass through and the captured ALU err is reported.
- Gap >=16 is legal; ALU timeout err is captured normally.

## Timing
- Reset (async, active-low): state IDLE, all outputs 0, `req_ready` 0 while reset low and 1 the first cycle after release; in-flight op and pending response discarded.
- Unsplit: rsp_valid rises 1+LAT edges after the accept edge.
- Split: rsp_valid rises 2+req_gap+LAT edges after the accept edge.
- `req_ready` is 0 in every state but IDLE; no request accepted while rsp pending.
- rsp_valid&rsp_ready: IDLE next cycle; new request acceptable that cycle (no same-cycle bypass).
- rsp_ready held high continuously: one op per 3+LAT cycles (unsplit).
- rsp_res/rsp_flags never change while rsp_valid=1.

## Test plan
- Reset low mid-WAIT of an ADD (mode=1,cmd=0) -> all outputs 0 immediately, after release rsp_valid stays 0 and req_ready=1.
- ADD opa=200 opb=100 cin=0, unsplit inp_valid=11, rsp_ready=1 -> alu_ce=1 one cycle later, rsp_valid 2 edges after accept, rsp_res=300, cout=1.
- MUL_INC (mode=1,cmd=9) opa=3 opb=4 -> WAIT lasts 2 cycles, rsp_valid 3 edges after accept, rsp_res=20.
- AND (mode=0) split, gap=5, opa=8'hF0 opb=8'h3C -> inp_valid 01 for 6 cycles then 10 for 1, rsp_res=8'h30, err=0, rsp_valid at edge 8.
- ADD split gap=16 -> ALU timeout, rsp_flags err=1 captured.
- rsp_ready held 0 for 10 cycles after response -> rsp_valid/rsp_res stable, req_ready=0, req_valid ignored; rsp_ready=1 -> IDLE next cycle.
